// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment value feeder.
// Holds the conversion FSM states and the BCD digit adjust helper.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  localparam int DEC_MAX = 9999;
  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4 * DIGITS;

  // Double-dabble correction: any digit of 5 or more would overflow past 9
  // after the coming shift, so bias it by 3 first.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_value_feed_if.sv
// Signal bundle between the value source and the feeder.
// The feeder is the slave; whoever loads values is the master.
interface ssd_value_feed_if;

  logic        load;
  logic [15:0] bin_in;
  logic        hex_mode;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] val_out;
  logic        smpl;

  modport master (
    output load, bin_in, hex_mode,
    input  busy, done, ovf, val_out, smpl
  );

  modport slave (
    input  load, bin_in, hex_mode,
    output busy, done, ovf, val_out, smpl
  );

endinterface

// File: rtl/ssd_refresh_tick.sv
// Free-running prescaler that emits a one-clock refresh strobe every
// REFRESH_DIV clocks for the display driver.
module ssd_refresh_tick #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic smpl
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // The strobe is registered off the terminal count, so it lands in the
  // cycle right after the counter sits at its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      smpl <= 1'b0;
    end else begin
      smpl <= (cnt == CNT_LAST);
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ssd_value_feed.sv
// Loads a 16-bit value, optionally converts it to packed BCD with a
// sequential double-dabble engine, and commits it tear-free to val_out.
module ssd_value_feed
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  ssd_value_feed_if.slave  bus
);

  localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

  state_t           state;
  state_t           state_next;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic [3:0]       iter;
  logic             clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.load) state_next = bus.hex_mode ? COMMIT : CONV;
      CONV:    if (iter == ITER_LAST) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The bcd register doubles as the result register: hex loads go straight
  // into it, decimal loads build up in it, and only COMMIT exposes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd         <= '0;
      bin         <= '0;
      iter        <= '0;
      clamp       <= 1'b0;
      bus.val_out <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.busy <= (state_next != IDLE);
      bus.done <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (bus.load) begin
            if (bus.hex_mode) begin
              bcd   <= bus.bin_in;
              clamp <= 1'b0;
            end else begin
              bcd  <= '0;
              iter <= '0;
              if (bus.bin_in > 16'(DEC_MAX)) begin
                bin   <= BIN_W'(DEC_MAX);
                clamp <= 1'b1;
              end else begin
                bin   <= bus.bin_in[BIN_W-1:0];
                clamp <= 1'b0;
              end
            end
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
          iter       <= iter + 4'd1;
        end
        COMMIT: begin
          bus.val_out <= bcd;
          bus.ovf     <= clamp;
        end
        default: ;
      endcase
    end
  end

  ssd_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .smpl (bus.smpl)
  );

endmodule

// File: tb/tb_ssd_value_feed.sv
// Scoreboard bench for ssd_value_feed: stimulus predicts commits from
// edge-counted timing rules, a negedge monitor checks every cycle.
module tb_ssd_value_feed;

  localparam int DIV = 4;

  typedef struct {
    logic [15:0] val;
    logic        ovf;
    int          commit_at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ssd_value_feed_if bus ();

  ssd_value_feed #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        sb[$];
  exp_t        mon_x;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          free_at = 0;
  int          acc_at = 0;
  int          com_at = 0;
  logic [15:0] last_val = '0;
  logic        last_ovf = 1'b0;

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d, t=%0t)",
               name, actual, expected, cyc, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle load; the model decides from edge timing alone
  // whether the feeder is idle at the sampling edge.
  task automatic applyStimulus(input logic [15:0] value, input logic hex);
    int   e;
    int   v;
    exp_t x;
    bus.bin_in   = value;
    bus.hex_mode = hex;
    bus.load     = 1'b1;
    e = cyc + 1;
    v = int'(value);
    if (e >= free_at) begin
      acc_at = e;
      if (hex) begin
        x.val  = value;
        x.ovf  = 1'b0;
        com_at = e + 1;
      end else begin
        x.val  = to_bcd((v > 9999) ? 9999 : v);
        x.ovf  = (v > 9999);
        com_at = e + 15;
      end
      x.commit_at = com_at;
      free_at     = com_at + 1;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    bus.load     = 1'b0;
    bus.bin_in   = 16'($urandom);
    bus.hex_mode = 1'($urandom);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_val_out", bus.val_out, 16'h0000);
    checkOutput("rst_busy", {15'b0, bus.busy}, 16'h0);
    checkOutput("rst_done", {15'b0, bus.done}, 16'h0);
    checkOutput("rst_ovf", {15'b0, bus.ovf}, 16'h0);
    checkOutput("rst_smpl", {15'b0, bus.smpl}, 16'h0);
    sb.delete();
    free_at  = 0;
    acc_at   = 0;
    com_at   = 0;
    last_val = '0;
    last_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge outside reset checks busy, the refresh
  // strobe, and either a commit against the scoreboard or a held value.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", {15'b0, bus.busy},
                  {15'b0, (cyc >= acc_at && cyc < com_at)});
      checkOutput("smpl", {15'b0, bus.smpl},
                  {15'b0, (cyc > 0 && (cyc % DIV) == 0)});
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_done: got done=1 with val_out %h, expected no commit (cycle %0d)",
                   bus.val_out, cyc);
        end else begin
          mon_x = sb.pop_front();
          checkOutput("commit_val", bus.val_out, mon_x.val);
          checkOutput("commit_ovf", {15'b0, bus.ovf}, {15'b0, mon_x.ovf});
          checkOutput("commit_cycle", 16'(cyc), 16'(mon_x.commit_at));
          last_val = mon_x.val;
          last_ovf = mon_x.ovf;
        end
      end else begin
        checkOutput("hold_val", bus.val_out, last_val);
        checkOutput("hold_ovf", {15'b0, bus.ovf}, {15'b0, last_ovf});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] v;
    logic        h;
    bus.load     = 1'b0;
    bus.bin_in   = '0;
    bus.hex_mode = 1'b0;

    doReset();

    applyStimulus(16'd1234, 1'b0);
    waitCycles(16);
    applyStimulus(16'hBEEF, 1'b1);
    waitCycles(2);
    applyStimulus(16'd42, 1'b0);
    waitCycles(16);

    applyStimulus(16'd12345, 1'b0);
    waitCycles(16);
    applyStimulus(16'd9999, 1'b0);
    waitCycles(16);
    applyStimulus(16'd0, 1'b0);
    waitCycles(16);
    applyStimulus(16'd10000, 1'b0);
    waitCycles(16);
    applyStimulus(16'hFFFF, 1'b0);
    waitCycles(16);

    // Loads at edge 7 and at the commit edge must be dropped; the one
    // after the commit edge is accepted.
    applyStimulus(16'd5678, 1'b0);
    waitCycles(6);
    applyStimulus(16'd1111, 1'b0);
    waitCycles(7);
    applyStimulus(16'd1111, 1'b0);
    applyStimulus(16'h0777, 1'b1);
    waitCycles(2);

    applyStimulus(16'd4321, 1'b0);
    waitCycles(5);
    doReset();
    waitCycles(3);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else                           v = 16'($urandom_range(0, 9999));
      h = ($urandom_range(0, 2) == 0);
      applyStimulus(v, h);
      waitCycles($urandom_range(0, 18));
      if (i == 100) begin
        waitCycles($urandom_range(0, 6));
        doReset();
      end
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) waitCycles(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d commits outstanding, expected 0", sb.size());
    end
    waitCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_value_feed.md
# ssd_value_feed

Upstream feeder for the four-digit seven-segment display driver. Accepts a 16-bit value on a load strobe, optionally converts it from binary to packed BCD with a sequential double-dabble engine, and presents a tear-free 16-bit nibble word (`val_out`) to the driver's `val_in`. Also generates the driver's `smpl` refresh strobe from the system clock.

## Interface
- `REFRESH_DIV`, default 50000: clk cycles per `smpl` pulse; legal range ≥ 2.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `load` in 1: single-cycle request; samples `bin_in` and `hex_mode`.
- `bin_in` in 16: value to display.
- `hex_mode` in 1: 1 = pass `bin_in` through as raw hex digits; 0 = decimal conversion.
- `busy` out 1: conversion in progress; `load` is ignored while high.
- `done` out 1: one-cycle pulse when `val_out` has been updated.
- `ovf` out 1: last committed decimal value was clamped; held until the next commit.
- `val_out` out 16: four nibble digits for the driver, most significant digit in [15:12].
- `smpl` out 1: registered one-clk-wide refresh pulse for the driver.

## Operation
- FSM states: IDLE, CONV, COMMIT.
- **IDLE, `load`=1, `hex_mode`=1:**
  - Capture `bin_in` into the result register.
  - Next state COMMIT; `busy` goes 1.
- **IDLE, `load`=1, `hex_mode`=0:**
  - Clamp: if `bin_in` > 9999, capture 9999 and set an internal clamp flag; otherwise capture `bin_in[13:0]`.
  - Clear the BCD accumulator; iteration counter = 0.
  - Next state CONV; `busy` goes 1.
- **CONV:** one double-dabble iteration per edge.
  - Each BCD nibble ≥ 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - After the 14th iteration (counter = 13), next state COMMIT.
- **COMMIT:**
  - `val_out` ← result; `ovf` ← clamp flag (0 in hex mode).
  - `done` ← 1 for exactly one cycle; `busy` ← 0.
  - Next state IDLE.
- `val_out` changes only at COMMIT. It never shows partial results.
- `load` while `busy`=1 is dropped, not queued.
- `load` in the same cycle as the COMMIT edge is dropped. It is accepted from the following cycle (IDLE).
- **Refresh counter:**
  - Counts 0..`REFRESH_DIV`-1 and wraps.
  - `smpl` = 1 during the cycle after the counter reaches `REFRESH_DIV`-1.
  - Runs continuously, independent of the FSM.
- **Reset values** (immediate, asynchronous, including mid-conversion):
  - `val_out`=0, `busy`=0, `done`=0, `ovf`=0, `smpl`=0.
  - Refresh counter = 0, state IDLE; any partial conversion is discarded.

## Timing
- Decimal: `load` sampled at edge 0.
  - `busy`=1 after edges 0..14.
  - `val_out` valid and `done`=1 after edge 15; `busy`=0 after edge 15.
  - Total latency 15 clk.
- Hex: `load` at edge 0, COMMIT at edge 1.
  - `val_out` and `done` after edge 1; latency 1 clk plus the commit edge.
- Back-to-back throughput: decimal one value per 16 clk; hex one value per 2 clk.
- `smpl` period is exactly `REFRESH_DIV` clk; high for 1 clk. First pulse after `REFRESH_DIV` edges from reset release.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ssd_pkg`:
  - FSM state typedef (IDLE, CONV, COMMIT).
  - `DEC_MAX` = 9999, `BIN_W` = 14, `DIGITS` = 4.
- Sub-module `ssd_refresh_tick`: parameterised prescaler producing `smpl`, with clk/rst only.
- Conversion FSM and datapath stay in the top module.

## Test plan
- Reset: assert `rst` mid-run → `val_out`=0x0000, `busy`/`done`/`ovf`/`smpl`=0 immediately; no `done` after release.
- Decimal: `load` with `bin_in`=1234, `hex_mode`=0 → `busy` high 15 clk; `val_out`=16'h1234 with a single-cycle `done` at edge 15; `ovf`=0.
- Hex and no tearing: load 16'hBEEF in hex mode → `val_out`=16'hBEEF at edge 1. Then load 42 decimal → `val_out` holds 16'hBEEF for 15 edges, then becomes 16'h0042.
- Overflow: load 12345 decimal → `val_out`=16'h9999, `ovf`=1. Then load 9999 → `val_out`=16'h9999, `ovf`=0. Boundaries: 0 → 16'h0000; 10000 → 16'h9999 with `ovf`=1.
- Dropped load: load 5678, then pulse `load` with 1111 at edge 7 and at the COMMIT edge → only 16'h5678 committed; exactly one `done`.
- Refresh: `REFRESH_DIV`=4 → `smpl` high 1 clk every 4 clk, steady across conversions; reset mid-count restarts the 4-clk period.
